// File: rtl/adc_rx_pkg.sv
// Shared FSM encoding, test-pattern constants and default sizing for the ADC receive
// calibration sequencer.
package adc_rx_pkg;

  localparam int unsigned LANES_DEF       = 10;
  localparam int unsigned TAP_W_DEF       = 9;
  localparam int unsigned MAX_TAP_DEF     = 511;
  localparam int unsigned RST_CYC_DEF     = 8;
  localparam int unsigned SETTLE_CYC_DEF  = 16;
  localparam int unsigned CHECK_CYC_DEF   = 64;
  localparam int unsigned MIN_WIN_DEF     = 8;
  localparam int unsigned DEFAULT_TAP_DEF = 0;

  // The ADC test pattern toggles every sample; either phase is acceptable.
  localparam logic [3:0] PAT_A = 4'b1010;
  localparam logic [3:0] PAT_B = 4'b0101;

  typedef enum logic [3:0] {
    StRstHold,
    StRstWait,
    StIdle,
    StLoad,
    StSettle,
    StCheck,
    StNextTap,
    StCenter,
    StNextLane
  } calib_state_e;

  function automatic logic is_pattern(input logic [3:0] word);
    return (word == PAT_A) || (word == PAT_B);
  endfunction

endpackage

// File: rtl/adc_rx_win_track.sv
// Tracks the current run of passing taps and the widest run seen so far for one lane sweep.
module adc_rx_win_track #(
  parameter int unsigned TAP_W = 9
) (
  input  logic             clk_div,
  input  logic             rst,
  input  logic             clear,
  input  logic             step,
  input  logic             tap_good,
  input  logic             last,
  input  logic [TAP_W-1:0] tap,
  output logic [TAP_W-1:0] best_start,
  output logic [TAP_W:0]   best_len
);

  logic [TAP_W-1:0] run_start_q, run_start_d, best_start_q, best_start_d, run_start_ext;
  logic [TAP_W:0]   run_len_q, run_len_d, best_len_q, best_len_d, run_len_ext;

  always_comb begin
    // Run as it stands once this tap's verdict is folded in.
    run_start_ext = (run_len_q == '0) ? tap : run_start_q;
    run_len_ext   = tap_good ? run_len_q + 1'b1 : run_len_q;

    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;

    if (clear) begin
      run_start_d  = '0;
      run_len_d    = '0;
      best_start_d = '0;
      best_len_d   = '0;
    end else if (step) begin
      if (!tap_good || last) begin
        // Strict compare keeps the earliest of equal-width windows.
        if (run_len_ext > best_len_q) begin
          best_start_d = run_start_ext;
          best_len_d   = run_len_ext;
        end
        run_len_d = '0;
      end else begin
        run_start_d = run_start_ext;
        run_len_d   = run_len_ext;
      end
    end
  end

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      run_start_q  <= '0;
      run_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
    end else begin
      run_start_q  <= run_start_d;
      run_len_q    <= run_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
    end
  end

  assign best_start = best_start_q;
  assign best_len   = best_len_q;

endmodule

// File: rtl/adc_rx_calib_ctrl.sv
// ADC LVDS receive calibration: sequences the IDELAY/ISERDES resets, sweeps every lane's
// IDELAY tap against the alternating test pattern and loads the centre of the widest window.
module adc_rx_calib_ctrl
  import adc_rx_pkg::*;
#(
  parameter int unsigned LANES       = LANES_DEF,
  parameter int unsigned TAP_W       = TAP_W_DEF,
  parameter int unsigned MAX_TAP     = MAX_TAP_DEF,
  parameter int unsigned RST_CYC     = RST_CYC_DEF,
  parameter int unsigned SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int unsigned CHECK_CYC   = CHECK_CYC_DEF,
  parameter int unsigned MIN_WIN     = MIN_WIN_DEF,
  parameter int unsigned DEFAULT_TAP = DEFAULT_TAP_DEF
) (
  input  logic               clk_div,
  input  logic               rst,
  input  logic               start,
  input  logic [4*LANES-1:0] data,
  output logic               rst_iodelay,
  output logic               rst_serdes,
  output logic [LANES-1:0]   load,
  output logic [TAP_W-1:0]   cntvaluein,
  output logic               busy,
  output logic               done,
  output logic [LANES-1:0]   lane_fail
);

  localparam int unsigned CNT_MAX_A = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > CHECK_CYC) ? CNT_MAX_A : CHECK_CYC;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
  localparam int unsigned LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;

  calib_state_e state_q, state_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [TAP_W-1:0]  tap_q, tap_d;
  logic              tap_good_q, tap_good_d;

  logic              rst_hold_q, rst_hold_d;
  logic              busy_q, busy_d;
  logic [LANES-1:0]  load_q, load_d;
  logic [TAP_W-1:0]  cntvaluein_q, cntvaluein_d;
  logic              done_q, done_d;
  logic [LANES-1:0]  lane_fail_q, lane_fail_d;

  logic              trk_clear, trk_step, trk_last;
  logic [TAP_W-1:0]  best_start;
  logic [TAP_W:0]    best_len;
  logic [TAP_W-1:0]  centre;

  logic [LANES-1:0]  smp [4];
  logic [3:0]        word;
  logic              word_pass;

  for (genvar k = 0; k < 4; k++) begin : g_smp
    assign smp[k] = data[k*LANES +: LANES];
  end

  // First sample in the MSB so the pattern reads left to right in time.
  assign word      = {smp[0][lane_q], smp[1][lane_q], smp[2][lane_q], smp[3][lane_q]};
  assign word_pass = is_pattern(word);
  assign trk_last  = (tap_q == TAP_W'(MAX_TAP));
  assign centre    = TAP_W'({1'b0, best_start} + (best_len >> 1));

  adc_rx_win_track #(
    .TAP_W(TAP_W)
  ) u_win_track (
    .clk_div   (clk_div),
    .rst       (rst),
    .clear     (trk_clear),
    .step      (trk_step),
    .tap_good  (tap_good_q),
    .last      (trk_last),
    .tap       (tap_q),
    .best_start(best_start),
    .best_len  (best_len)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lane_d       = lane_q;
    tap_d        = tap_q;
    tap_good_d   = tap_good_q;
    trk_clear    = 1'b0;
    trk_step     = 1'b0;
    load_d       = '0;
    cntvaluein_d = cntvaluein_q;
    done_d       = done_q;
    lane_fail_d  = lane_fail_q;

    unique case (state_q)
      StRstHold: begin
        if (cnt_q == CNT_W'(RST_CYC - 1)) begin
          cnt_d   = '0;
          state_d = StRstWait;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRstWait: begin
        if (cnt_q == CNT_W'(RST_CYC - 1)) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StIdle: begin
        if (start) begin
          lane_d      = '0;
          tap_d       = '0;
          trk_clear   = 1'b1;
          done_d      = 1'b0;
          lane_fail_d = '0;
          state_d     = StLoad;
        end
      end
      StLoad: begin
        cnt_d   = '0;
        state_d = StSettle;
      end
      StSettle: begin
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = StCheck;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCheck: begin
        if (!word_pass) begin
          tap_good_d = 1'b0;
          cnt_d      = '0;
          state_d    = StNextTap;
        end else if (cnt_q == CNT_W'(CHECK_CYC - 1)) begin
          tap_good_d = 1'b1;
          cnt_d      = '0;
          state_d    = StNextTap;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StNextTap: begin
        trk_step = 1'b1;
        if (trk_last) begin
          state_d = StCenter;
        end else begin
          tap_d   = tap_q + 1'b1;
          state_d = StLoad;
        end
      end
      StCenter: begin
        // Tracker has closed the final run by now; the centre strobe shows during NEXT_LANE.
        load_d[lane_q] = 1'b1;
        if (best_len >= (TAP_W+1)'(MIN_WIN)) begin
          cntvaluein_d = centre;
        end else begin
          cntvaluein_d        = TAP_W'(DEFAULT_TAP);
          lane_fail_d[lane_q] = 1'b1;
        end
        state_d = StNextLane;
      end
      StNextLane: begin
        if (lane_q == LANE_W'(LANES - 1)) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          lane_d    = lane_q + 1'b1;
          tap_d     = '0;
          trk_clear = 1'b1;
          state_d   = StLoad;
        end
      end
      default: state_d = StRstHold;
    endcase

    // Sweep strobe is registered alongside the state so it is high exactly during LOAD.
    if (state_d == StLoad) begin
      load_d[lane_d] = 1'b1;
      cntvaluein_d   = tap_d;
    end
  end

  assign rst_hold_d = (state_d == StRstHold);
  assign busy_d     = (state_d != StIdle);

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      state_q      <= StRstHold;
      cnt_q        <= '0;
      lane_q       <= '0;
      tap_q        <= '0;
      tap_good_q   <= 1'b0;
      rst_hold_q   <= 1'b1;
      busy_q       <= 1'b1;
      load_q       <= '0;
      cntvaluein_q <= '0;
      done_q       <= 1'b0;
      lane_fail_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lane_q       <= lane_d;
      tap_q        <= tap_d;
      tap_good_q   <= tap_good_d;
      rst_hold_q   <= rst_hold_d;
      busy_q       <= busy_d;
      load_q       <= load_d;
      cntvaluein_q <= cntvaluein_d;
      done_q       <= done_d;
      lane_fail_q  <= lane_fail_d;
    end
  end

  assign rst_iodelay = rst_hold_q;
  assign rst_serdes  = rst_hold_q;
  assign busy        = busy_q;
  assign load        = load_q;
  assign cntvaluein  = cntvaluein_q;
  assign done        = done_q;
  assign lane_fail   = lane_fail_q;

endmodule

// File: tb/tb_adc_rx_calib_ctrl.sv
// Randomised scoreboard bench: expected load strobes come from a per-lane window model,
// a monitor checks every strobe the sequencer emits.
module tb_adc_rx_calib_ctrl;

  localparam int LANES     = 10;
  localparam int TAP_W     = 9;
  localparam int MAX_TAP   = 511;
  localparam int MAX_TAP_S = 31;
  localparam int MIN_WIN   = 8;

  logic clk_div = 1'b0;
  logic rst     = 1'b1;
  logic start   = 1'b0;
  logic start_s = 1'b0;
  logic [4*LANES-1:0] data   = '0;
  logic [4*LANES-1:0] data_s = '0;

  logic             rst_iodelay, rst_serdes, busy, done;
  logic [LANES-1:0] load, lane_fail;
  logic [TAP_W-1:0] cntvaluein;
  logic             rst_iodelay_s, rst_serdes_s, busy_s, done_s;
  logic [LANES-1:0] load_s, lane_fail_s;
  logic [TAP_W-1:0] cntvaluein_s;

  always #5 clk_div = ~clk_div;

  adc_rx_calib_ctrl #(
    .LANES(LANES), .TAP_W(TAP_W), .MAX_TAP(MAX_TAP), .RST_CYC(8), .SETTLE_CYC(2),
    .CHECK_CYC(4), .MIN_WIN(MIN_WIN), .DEFAULT_TAP(0)
  ) dut (
    .clk_div(clk_div), .rst(rst), .start(start), .data(data),
    .rst_iodelay(rst_iodelay), .rst_serdes(rst_serdes), .load(load),
    .cntvaluein(cntvaluein), .busy(busy), .done(done), .lane_fail(lane_fail)
  );

  adc_rx_calib_ctrl #(
    .LANES(LANES), .TAP_W(TAP_W), .MAX_TAP(MAX_TAP_S), .RST_CYC(8), .SETTLE_CYC(2),
    .CHECK_CYC(4), .MIN_WIN(MIN_WIN), .DEFAULT_TAP(0)
  ) dut_s (
    .clk_div(clk_div), .rst(rst), .start(start_s), .data(data_s),
    .rst_iodelay(rst_iodelay_s), .rst_serdes(rst_serdes_s), .load(load_s),
    .cntvaluein(cntvaluein_s), .busy(busy_s), .done(done_s), .lane_fail(lane_fail_s)
  );

  typedef struct {
    int lane;
    int val;
  } ld_t;

  ld_t exp_q[$];
  ld_t exp_s_q[$];
  bit  pass_map [LANES][MAX_TAP+1];
  int  tap_now [LANES];
  logic [LANES-1:0] exp_fail;
  int  vectors = 0;
  int  miscompares = 0;

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_iodelay_reset", int'(rst_iodelay), 1);
    check("rst_serdes_reset", int'(rst_serdes), 1);
    check("busy_reset", int'(busy), 1);
    check("load_reset", int'(load), 0);
    check("cntvaluein_reset", int'(cntvaluein), 0);
    check("done_reset", int'(done), 0);
    check("lane_fail_reset", int'(lane_fail), 0);
  endtask

  task automatic set_window(input int l, input int lo, input int hi);
    for (int t = lo; t <= hi && t <= MAX_TAP; t++) pass_map[l][t] = 1'b1;
  endtask

  task automatic clear_lane(input int l);
    for (int t = 0; t <= MAX_TAP; t++) pass_map[l][t] = 1'b0;
  endtask

  task automatic rand_maps();
    int n, lo, len;
    for (int l = 0; l < LANES; l++) begin
      clear_lane(l);
      n = $urandom_range(0, 3);
      for (int w = 0; w < n; w++) begin
        lo  = $urandom_range(0, MAX_TAP);
        len = $urandom_range(1, 40);
        set_window(l, lo, lo + len - 1);
      end
    end
  endtask

  // Widest maximal window of passing taps, earliest on ties; centre is start + width/2.
  task automatic model_lane(input int l, output int centre, output bit fail);
    int best_s, best_l, len;
    best_s = 0;
    best_l = 0;
    for (int s = 0; s <= MAX_TAP; s++) begin
      if (pass_map[l][s] && (s == 0 || !pass_map[l][s-1])) begin
        len = 0;
        while (s + len <= MAX_TAP && pass_map[l][s+len]) len++;
        if (len > best_l) begin
          best_l = len;
          best_s = s;
        end
      end
    end
    fail   = (best_l < MIN_WIN);
    centre = fail ? 0 : best_s + best_l / 2;
  endtask

  task automatic push_expected();
    int  c;
    bit  f;
    ld_t e;
    for (int l = 0; l < LANES; l++) begin
      for (int t = 0; t <= MAX_TAP; t++) begin
        e.lane = l;
        e.val  = t;
        exp_q.push_back(e);
      end
      model_lane(l, c, f);
      e.lane = l;
      e.val  = c;
      exp_q.push_back(e);
      exp_fail[l] = f;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk_div);
    start = 1'b1;
    @(negedge clk_div);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(negedge clk_div);
      n++;
    end
    check("done_set", int'(done), 1);
  endtask

  // IDELAY/ADC model for the swept instance: pattern only where the lane's current tap passes.
  initial begin
    logic [3:0] nib;
    for (int l = 0; l < LANES; l++) tap_now[l] = 0;
    forever begin
      @(negedge clk_div);
      for (int l = 0; l < LANES; l++) begin
        if (load[l] === 1'b1) tap_now[l] = int'(cntvaluein);
        if (pass_map[l][tap_now[l]]) begin
          nib = ($urandom_range(0, 1) == 1) ? 4'b1010 : 4'b0101;
        end else begin
          nib = 4'($urandom_range(0, 15));
          if (nib == 4'b1010 || nib == 4'b0101) nib = nib ^ 4'b0001;
        end
        data[l]           = nib[3];
        data[LANES+l]     = nib[2];
        data[2*LANES+l]   = nib[1];
        data[3*LANES+l]   = nib[0];
      end
    end
  end

  initial begin
    logic [3:0] nib;
    forever begin
      @(negedge clk_div);
      for (int l = 0; l < LANES; l++) begin
        nib = ($urandom_range(0, 1) == 1) ? 4'b1010 : 4'b0101;
        data_s[l]         = nib[3];
        data_s[LANES+l]   = nib[2];
        data_s[2*LANES+l] = nib[1];
        data_s[3*LANES+l] = nib[0];
      end
    end
  end

  initial begin
    int  idx;
    ld_t e;
    forever begin
      @(negedge clk_div);
      if (rst === 1'b0 && load !== '0) begin
        idx = -1;
        for (int i = 0; i < LANES; i++) if (load[i] === 1'b1) idx = i;
        check("load_onehot", $countones(load), 1);
        if (exp_q.size() == 0) begin
          check("unexpected_load_lane", idx, -1);
        end else begin
          e = exp_q.pop_front();
          check("load_lane", idx, e.lane);
          check("load_tap", int'(cntvaluein), e.val);
        end
      end
    end
  end

  initial begin
    int  idx;
    ld_t e;
    forever begin
      @(negedge clk_div);
      if (rst === 1'b0 && load_s !== '0) begin
        idx = -1;
        for (int i = 0; i < LANES; i++) if (load_s[i] === 1'b1) idx = i;
        check("small_load_onehot", $countones(load_s), 1);
        if (exp_s_q.size() == 0) begin
          check("small_unexpected_load_lane", idx, -1);
        end else begin
          e = exp_s_q.pop_front();
          check("small_load_lane", idx, e.lane);
          check("small_load_tap", int'(cntvaluein_s), e.val);
        end
      end
    end
  end

  initial begin
    ld_t e;
    int  n;

    repeat (3) @(negedge clk_div);
    check_reset_vals();
    check("small_busy_reset", int'(busy_s), 1);

    rst = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk_div);
      check("rst_iodelay_seq", int'(rst_iodelay), int'(k < 8));
      check("rst_serdes_seq", int'(rst_serdes), int'(k < 8));
      check("busy_seq", int'(busy), int'(k < 16));
      check("load_seq", int'(load), 0);
    end

    // Every tap passes on every lane of the short sweep.
    for (int l = 0; l < LANES; l++) begin
      for (int t = 0; t <= MAX_TAP_S; t++) begin
        e.lane = l;
        e.val  = t;
        exp_s_q.push_back(e);
      end
      e.lane = l;
      e.val  = 16;
      exp_s_q.push_back(e);
    end
    @(negedge clk_div);
    start_s = 1'b1;
    @(negedge clk_div);
    start_s = 1'b0;
    n = 0;
    while (done_s !== 1'b1 && n < 5000) begin
      @(negedge clk_div);
      n++;
    end
    check("small_done", int'(done_s), 1);
    check("small_lane_fail", int'(lane_fail_s), 0);
    check("small_busy_idle", int'(busy_s), 0);
    check("small_queue_empty", exp_s_q.size(), 0);

    // Directed windows plus random lanes.
    rand_maps();
    clear_lane(0); set_window(0, 500, 511);
    clear_lane(1); set_window(1, 10, 21); set_window(1, 500, 511);
    clear_lane(2); set_window(2, 40, 47);
    clear_lane(3); set_window(3, 100, 139); set_window(3, 300, 309);
    clear_lane(4); set_window(4, 200, 206);
    clear_lane(7);
    push_expected();
    pulse_start();
    check("busy_after_start", int'(busy), 1);
    check("done_after_start", int'(done), 0);
    repeat (3000) @(negedge clk_div);
    pulse_start();
    wait_done(60000);
    check("lane_fail_cal1", int'(lane_fail), int'(exp_fail));
    check("busy_after_cal1", int'(busy), 0);
    check("queue_empty_cal1", exp_q.size(), 0);

    // Second sweep interrupted by reset while on lane 5.
    rand_maps();
    push_expected();
    pulse_start();
    check("done_cleared", int'(done), 0);
    check("lane_fail_cleared", int'(lane_fail), 0);
    n = 0;
    while (load[5] !== 1'b1 && n < 40000) begin
      @(negedge clk_div);
      n++;
    end
    check("lane5_reached", int'(load[5]), 1);
    repeat (30) @(negedge clk_div);
    @(posedge clk_div);
    #2 rst = 1'b1;
    #1 check_reset_vals();
    exp_q.delete();
    repeat (3) @(negedge clk_div);
    rst = 1'b0;
    repeat (20) @(negedge clk_div);
    check("busy_after_rerst", int'(busy), 0);
    check("rst_iodelay_after_rerst", int'(rst_iodelay), 0);
    repeat (100) @(negedge clk_div);
    check("no_resume_busy", int'(busy), 0);
    check("no_resume_done", int'(done), 0);

    // Fresh calibration from lane 0.
    rand_maps();
    push_expected();
    pulse_start();
    wait_done(60000);
    check("lane_fail_cal3", int'(lane_fail), int'(exp_fail));
    check("busy_after_cal3", int'(busy), 0);
    check("queue_empty_cal3", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adc_rx_calib_ctrl.md
Name: adc_rx_calib_ctrl

Overview:
- Calibration sequencer for the 10-lane e2v ADC LVDS receive path (IBUFDS -> IDELAY -> 1:4 ISERDES -> realign).
- Runs at the clk_div rate.
- After reset, it drives the IDELAY/ISERDES reset sequence. On request, it sweeps the IDELAY tap of each lane while the ADC outputs its alternating test pattern.
- It finds the widest passing window per lane and loads the window-centre tap. It reports per-lane failures and overall done.

Parameters:
- LANES, 10, number of data lanes (bits per sample).
- TAP_W, 9, IDELAY CNTVALUEIN width.
- MAX_TAP, 511, highest tap swept.
- RST_CYC, 8, cycles the primitive resets are held, then cycles waited after release.
- SETTLE_CYC, 16, cycles ignored after each load pulse (receive pipeline plus IDELAY settle).
- CHECK_CYC, 64, consecutive words that must all pass for a tap to count as good.
- MIN_WIN, 8, minimum passing-window width (taps) for a lane to be declared good.
- DEFAULT_TAP, 0, tap loaded into a failed lane.

Ports:
- clk_div  in  1  156.25 MHz divided clock; only clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to calibrate; ignored unless in IDLE.
- data  in  4*LANES  realigned words from the receiver; [9:0] is the first sample, sample k is in [10k+9:10k].
- rst_iodelay  out  1  IDELAY reset.
- rst_serdes  out  1  ISERDES reset.
- load  out  LANES  per-lane one-cycle load strobe.
- cntvaluein  out  TAP_W  tap value broadcast to all lanes, qualified by load.
- busy  out  1  high in every state except IDLE.
- done  out  1  sticky high after a completed calibration; cleared on start.
- lane_fail  out  LANES  sticky per-lane failure; cleared on start.

Behaviour:
- Reset values: rst_iodelay=1, rst_serdes=1, busy=1, load=0, cntvaluein=0, done=0, lane_fail=0, FSM in RST_HOLD. All outputs are registered.
- RST_HOLD: both resets held for RST_CYC cycles, then go to RST_WAIT.
- RST_WAIT: both resets low for RST_CYC cycles, then go to IDLE.
- IDLE: busy=0. On start: set lane=0, tap=0, best_len=0, run_len=0; clear done and lane_fail; go to LOAD.
- LOAD: load[lane]=1 for exactly 1 cycle with cntvaluein=tap. Go to SETTLE.
- SETTLE: wait SETTLE_CYC cycles, then go to CHECK.
- CHECK: evaluate CHECK_CYC consecutive words.
  - A word passes when {s0[lane],s1[lane],s2[lane],s3[lane]} is 4'b1010 or 4'b0101.
  - Any failing word aborts CHECK early with tap_good=0.
- NEXT_TAP, when tap_good:
  - If run_len=0, set run_start=tap.
  - run_len += 1.
- NEXT_TAP, when not tap_good:
  - Close the run: if run_len > best_len, then best_start=run_start and best_len=run_len.
  - Set run_len=0.
- NEXT_TAP, advance: if tap==MAX_TAP, first close any open run as above, then go to CENTER. Otherwise tap += 1 and go to LOAD.
- Run ties: strict greater-than, so the earliest of equal-length windows wins.
- CENTER:
  - If best_len >= MIN_WIN: centre = best_start + (best_len >> 1), truncated.
  - Otherwise: centre = DEFAULT_TAP and set lane_fail[lane].
  - Pulse load[lane] with cntvaluein=centre (1 cycle). Go to NEXT_LANE.
- NEXT_LANE:
  - If lane==LANES-1: set done and go to IDLE.
  - Otherwise: lane += 1, tap=0, best_len=0, run_len=0, go to LOAD.
- Widths: run_len and best_len are TAP_W+1 bits, so a full window of 512 taps is representable. The centre sum is computed at TAP_W+1 bits and fits TAP_W.
- Only one load bit is ever high in a cycle. cntvaluein is stable during that load cycle.
- start while busy: ignored. No queuing.
- Asynchronous rst mid-sweep: immediate return to reset values. The reset sequence reruns, and calibration does not resume.
- Calibration duration per lane: (MAX_TAP+1)*(1+SETTLE_CYC+CHECK_CYC+1) + 2 cycles, worst case with all taps passing.

Decomposition:
- Package adc_rx_pkg holds:
  - the FSM state enum (RST_HOLD, RST_WAIT, IDLE, LOAD, SETTLE, CHECK, NEXT_TAP, CENTER, NEXT_LANE);
  - the pattern constants 4'b1010 and 4'b0101;
  - the default parameter values.
- One sub-module: adc_rx_win_track. It holds the run/best window tracker: tap, tap_good and step inputs, a clear input, and best_start/best_len outputs.

Test Plan:
- Reset release -> rst_iodelay=rst_serdes=1 for 8 cycles, then 0; busy falls 8 cycles later. Check load=0 throughout.
- All lanes pass at every tap (MAX_TAP=31, MIN_WIN=8) -> each lane receives 32 sweep loads followed by a centre load with cntvaluein=16. done=1, lane_fail=0.
- Lane 3 passes only on taps 100..139 and on 300..309 (MAX_TAP=511) -> lane 3 centre load=120, lane_fail[3]=0.
- Lane 7 never passes -> lane 7 final load=DEFAULT_TAP (0), lane_fail=10'h080, done=1.
- A window open through MAX_TAP (taps 500..511 pass) -> the window is closed at sweep end and the centre is 506. A tie with taps 10..21 picks centre 16.
- start pulsed mid-sweep is ignored. rst asserted mid-sweep on lane 5 -> all outputs return to reset values in the same cycle. A later start recalibrates from lane 0.
